// File: rtl/morse_interval_classifier_pkg.sv
// Shared encodings for the Morse keying front end: event codes and the
// classifier state encoding used by the interval classifier and its consumers.
package morse_pkg;

    localparam int EVT_CODE_W = 3;

    localparam logic [EVT_CODE_W-1:0] EVT_DIT    = 3'd0;
    localparam logic [EVT_CODE_W-1:0] EVT_DASH   = 3'd1;
    localparam logic [EVT_CODE_W-1:0] EVT_INTRA  = 3'd2;
    localparam logic [EVT_CODE_W-1:0] EVT_LETTER = 3'd3;
    localparam logic [EVT_CODE_W-1:0] EVT_WORD   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MARK     = 2'd1,
        ST_GAP      = 2'd2,
        ST_GAP_DONE = 2'd3
    } morse_state_e;

endpackage

// File: rtl/morse_interval_classifier_tick_prescaler.sv
// Free-running tick generator: one-cycle tick every PRESCALE clocks, with a
// synchronous clear that restarts the period from zero.
module tick_prescaler #(
    parameter int PRESCALE = 60000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        tick  = (pre_q == LAST);
        pre_d = pre_q + PW'(1);
        if (clr || tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/morse_interval_classifier.sv
// Times key-down and key-up runs with a prescaled saturating counter, classifies
// each run against the speed reference and hands one event per run downstream.
module morse_interval_classifier
    import morse_pkg::*;
#(
    parameter int PRESCALE = 60000,
    parameter int CNT_W    = 12,
    parameter int OUT_W    = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key,
    input  logic [OUT_W-1:0]      ref_in,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [EVT_CODE_W-1:0] evt_code,
    output logic [OUT_W-1:0]      evt_len,
    output logic                  overrun,
    output logic [OUT_W-1:0]      count_out,
    output logic                  dash_dit,
    output logic                  space
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] OUT_MAX = {{(CNT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    function automatic logic [OUT_W-1:0] sat_out(input logic [CNT_W-1:0] v);
        if (v >= OUT_MAX) begin
            return '1;
        end
        return v[OUT_W-1:0];
    endfunction

    morse_state_e          state_q, state_d;
    logic                  key_q, key_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  evt_valid_q, evt_valid_d;
    logic [EVT_CODE_W-1:0] evt_code_q, evt_code_d;
    logic [OUT_W-1:0]      evt_len_q, evt_len_d;
    logic                  overrun_q, overrun_d;
    logic [OUT_W-1:0]      count_out_q, count_out_d;
    logic                  dash_dit_q, dash_dit_d;
    logic                  space_q, space_d;

    logic                  key_edge;
    logic                  tick;
    logic                  pre_clr;
    logic [CNT_W-1:0]      run_len;
    logic [CNT_W-1:0]      ref_ext;
    logic [CNT_W-1:0]      sp_ref;
    logic                  emit;
    logic [EVT_CODE_W-1:0] emit_code;
    logic [OUT_W-1:0]      emit_len;

    assign key_edge = key ^ key_q;
    assign pre_clr  = key_edge || (state_q == ST_IDLE);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (reset),
        .clr  (pre_clr),
        .tick (tick)
    );

    // run_len includes this cycle's tick, so a run of N cycles reads floor(N/PRESCALE)
    // on its closing edge and the gap timeout fires on the very tick that crosses sp_ref.
    always_comb begin
        key_d   = key;
        ref_ext = CNT_W'(ref_in);
        sp_ref  = ref_ext + (ref_ext << 1);
        run_len = count_q;
        if (tick && (count_q != CNT_MAX)) begin
            run_len = count_q + CNT_W'(1);
        end
        count_d = pre_clr ? '0 : run_len;
        emit_len = sat_out(run_len);
    end

    // Classifier FSM: edges close a run; a long gap flushes a WORD without an edge.
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_code = EVT_DIT;
        case (state_q)
            ST_IDLE: begin
                if (key_edge && key) begin
                    state_d = ST_MARK;
                end
            end
            ST_MARK: begin
                if (key_edge) begin
                    emit      = 1'b1;
                    emit_code = (run_len <= ref_ext) ? EVT_DIT : EVT_DASH;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (key_edge) begin
                    emit    = 1'b1;
                    state_d = ST_MARK;
                    if (run_len <= ref_ext) begin
                        emit_code = EVT_INTRA;
                    end else if (run_len <= sp_ref) begin
                        emit_code = EVT_LETTER;
                    end else begin
                        emit_code = EVT_WORD;
                    end
                end else if (run_len > sp_ref) begin
                    emit      = 1'b1;
                    emit_code = EVT_WORD;
                    state_d   = ST_GAP_DONE;
                end
            end
            ST_GAP_DONE: begin
                if (key_edge) begin
                    state_d = ST_MARK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: valid/ready handshake. An event transfers on any cycle where
    // evt_valid && evt_ready; a fresh emission may refill the slot in that same cycle.
    // An emission that finds the slot full and not being accepted is dropped (sticky overrun).
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_len_d   = evt_len_q;
        overrun_d   = overrun_q;
        if (emit && (!evt_valid_q || evt_ready)) begin
            evt_valid_d = 1'b1;
            evt_code_d  = emit_code;
            evt_len_d   = emit_len;
        end else if (emit) begin
            overrun_d = 1'b1;
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_comb begin
        count_out_d = '0;
        dash_dit_d  = 1'b0;
        space_d     = 1'b0;
        if (state_q != ST_IDLE) begin
            count_out_d = sat_out(count_q);
            dash_dit_d  = (count_q > ref_ext);
            space_d     = (count_q > sp_ref);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            key_q       <= 1'b0;
            count_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
            evt_len_q   <= '0;
            overrun_q   <= 1'b0;
            count_out_q <= '0;
            dash_dit_q  <= 1'b0;
            space_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            count_q     <= count_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_len_q   <= evt_len_d;
            overrun_q   <= overrun_d;
            count_out_q <= count_out_d;
            dash_dit_q  <= dash_dit_d;
            space_q     <= space_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_len   = evt_len_q;
    assign overrun   = overrun_q;
    assign count_out = count_out_q;
    assign dash_dit  = dash_dit_q;
    assign space     = space_q;

endmodule

// File: tb/tb_morse_interval_classifier.sv
// Directed bench for the Morse interval classifier at PRESCALE=4: classification,
// gap timeout, handshake/overrun, saturation and asynchronous reset.
module tb_morse_interval_classifier;
    import morse_pkg::*;

    localparam int PRESCALE = 4;
    localparam int CNT_W    = 12;
    localparam int OUT_W    = 9;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  key = 1'b0;
    logic [OUT_W-1:0]      ref_in = 9'd2;
    logic                  evt_valid;
    logic                  evt_ready = 1'b1;
    logic [EVT_CODE_W-1:0] evt_code;
    logic [OUT_W-1:0]      evt_len;
    logic                  overrun;
    logic [OUT_W-1:0]      count_out;
    logic                  dash_dit;
    logic                  space;

    int checks   = 0;
    int failures = 0;

    morse_interval_classifier #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .ref_in    (ref_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_len   (evt_len),
        .overrun   (overrun),
        .count_out (count_out),
        .dash_dit  (dash_dit),
        .space     (space)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [OUT_W-1:0] r);
        #1;
        reset     = 1'b1;
        key       = 1'b0;
        evt_ready = 1'b1;
        ref_in    = r;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        do_reset(9'd2);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", evt_valid); end
        checks++; if (evt_code !== 3'd0) begin failures++; $display("FAIL rst_code got=%0d exp=0", evt_code); end
        checks++; if (evt_len !== 9'd0) begin failures++; $display("FAIL rst_len got=%0d exp=0", evt_len); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%0b exp=0", overrun); end
        checks++; if (count_out !== 9'd0) begin failures++; $display("FAIL rst_count_out got=%0d exp=0", count_out); end
        checks++; if (dash_dit !== 1'b0 || space !== 1'b0) begin failures++; $display("FAIL rst_live got=%0b%0b exp=00", dash_dit, space); end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
        step(10);
        checks++; if (evt_valid !== 1'b0 || count_out !== 9'd0 || dut.state_q !== ST_IDLE) begin
            failures++; $display("FAIL idle_hold got valid=%0b cnt=%0d st=%0d exp 0/0/IDLE", evt_valid, count_out, dut.state_q);
        end
    endtask

    task automatic test_dit();
        do_reset(9'd2);
        key = 1'b1;
        step(8);
        checks++; if (count_out !== 9'd1 || dash_dit !== 1'b0) begin
            failures++; $display("FAIL dit_live got cnt=%0d dd=%0b exp cnt=1 dd=0", count_out, dash_dit);
        end
        key = 1'b0;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_DIT || evt_len !== 9'd2) begin
            failures++; $display("FAIL dit_event got v=%0b c=%0d l=%0d exp v=1 c=0 l=2", evt_valid, evt_code, evt_len);
        end
        step(1);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL dit_one_cycle got=%0b exp=0", evt_valid); end
    endtask

    task automatic test_dash_letter_intra();
        do_reset(9'd2);
        key = 1'b1;
        step(12);
        checks++; if (count_out !== 9'd2 || dash_dit !== 1'b0) begin
            failures++; $display("FAIL dash_live got cnt=%0d dd=%0b exp cnt=2 dd=0", count_out, dash_dit);
        end
        key = 1'b0;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_DASH || evt_len !== 9'd3) begin
            failures++; $display("FAIL dash_event got v=%0b c=%0d l=%0d exp v=1 c=1 l=3", evt_valid, evt_code, evt_len);
        end
        step(11);
        key = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_LETTER || evt_len !== 9'd3) begin
            failures++; $display("FAIL letter_event got v=%0b c=%0d l=%0d exp v=1 c=3 l=3", evt_valid, evt_code, evt_len);
        end
        step(7);
        key = 1'b0;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_DIT || evt_len !== 9'd2) begin
            failures++; $display("FAIL dit2_event got v=%0b c=%0d l=%0d exp v=1 c=0 l=2", evt_valid, evt_code, evt_len);
        end
        step(7);
        key = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_INTRA || evt_len !== 9'd2) begin
            failures++; $display("FAIL intra_event got v=%0b c=%0d l=%0d exp v=1 c=2 l=2", evt_valid, evt_code, evt_len);
        end
    endtask

    task automatic test_word_timeout();
        int early;
        do_reset(9'd2);
        key = 1'b1;
        step(8);
        key = 1'b0;
        step(1);
        early = 0;
        for (int i = 2; i <= 28; i++) begin
            step(1);
            if (evt_valid !== 1'b0) early++;
        end
        checks++; if (early != 0) begin failures++; $display("FAIL word_early got=%0d exp=0", early); end
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_WORD || evt_len !== 9'd7) begin
            failures++; $display("FAIL word_event got v=%0b c=%0d l=%0d exp v=1 c=4 l=7", evt_valid, evt_code, evt_len);
        end
        early = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (evt_valid !== 1'b0) early++;
        end
        checks++; if (early != 0) begin failures++; $display("FAIL word_once got=%0d exp=0", early); end
        checks++; if (count_out !== 9'd11 || dash_dit !== 1'b1 || space !== 1'b1) begin
            failures++; $display("FAIL gapdone_live got cnt=%0d dd=%0b sp=%0b exp 11/1/1", count_out, dash_dit, space);
        end
        key = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL gapdone_no_event got=%0b exp=0", evt_valid); end
        step(11);
        key = 1'b0;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_DASH || evt_len !== 9'd3) begin
            failures++; $display("FAIL after_word_dash got v=%0b c=%0d l=%0d exp v=1 c=1 l=3", evt_valid, evt_code, evt_len);
        end
    endtask

    task automatic test_overrun();
        do_reset(9'd2);
        evt_ready = 1'b0;
        key = 1'b1;
        step(8);
        key = 1'b0;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_DIT || overrun !== 1'b0) begin
            failures++; $display("FAIL ovr_first got v=%0b c=%0d o=%0b exp v=1 c=0 o=0", evt_valid, evt_code, overrun);
        end
        step(7);
        key = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_DIT || evt_len !== 9'd2 || overrun !== 1'b1) begin
            failures++; $display("FAIL ovr_drop got v=%0b c=%0d l=%0d o=%0b exp v=1 c=0 l=2 o=1", evt_valid, evt_code, evt_len, overrun);
        end
        evt_ready = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b0 || overrun !== 1'b1) begin
            failures++; $display("FAIL ovr_accept got v=%0b o=%0b exp v=0 o=1", evt_valid, overrun);
        end
        step(5);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset(9'd2);
        evt_ready = 1'b0;
        key = 1'b1;
        step(8);
        key = 1'b0;
        step(1);
        step(7);
        key = 1'b1;
        evt_ready = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_INTRA || evt_len !== 9'd2 || overrun !== 1'b0) begin
            failures++; $display("FAIL b2b_load got v=%0b c=%0d l=%0d o=%0b exp v=1 c=2 l=2 o=0", evt_valid, evt_code, evt_len, overrun);
        end
        step(1);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%0b exp=0", evt_valid); end
    endtask

    task automatic test_ref_zero();
        do_reset(9'd0);
        key = 1'b1;
        step(4);
        key = 1'b0;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_DASH || evt_len !== 9'd1) begin
            failures++; $display("FAIL ref0_dash got v=%0b c=%0d l=%0d exp v=1 c=1 l=1", evt_valid, evt_code, evt_len);
        end
        step(3);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL ref0_quiet got=%0b exp=0", evt_valid); end
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_WORD || evt_len !== 9'd1) begin
            failures++; $display("FAIL ref0_word got v=%0b c=%0d l=%0d exp v=1 c=4 l=1", evt_valid, evt_code, evt_len);
        end
    endtask

    task automatic test_saturation();
        do_reset(9'd511);
        key = 1'b1;
        step(4096 * 4 + 40);
        checks++; if (dut.count_q !== 12'd4095) begin failures++; $display("FAIL sat_count got=%0d exp=4095", dut.count_q); end
        checks++; if (count_out !== 9'd511 || dash_dit !== 1'b1 || space !== 1'b1) begin
            failures++; $display("FAIL sat_live got cnt=%0d dd=%0b sp=%0b exp 511/1/1", count_out, dash_dit, space);
        end
        key = 1'b0;
        step(1);
        checks++; if (evt_valid !== 1'b1 || evt_code !== EVT_DASH || evt_len !== 9'd511) begin
            failures++; $display("FAIL sat_dash got v=%0b c=%0d l=%0d exp v=1 c=1 l=511", evt_valid, evt_code, evt_len);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        do_reset(9'd2);
        evt_ready = 1'b0;
        key = 1'b1;
        step(8);
        key = 1'b0;
        step(8);
        key = 1'b1;
        step(1);
        checks++; if (evt_valid !== 1'b1 || overrun !== 1'b1) begin
            failures++; $display("FAIL ar_setup got v=%0b o=%0b exp v=1 o=1", evt_valid, overrun);
        end
        step(5);
        #2;
        reset = 1'b1;
        key   = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0 || evt_code !== 3'd0 || evt_len !== 9'd0 || overrun !== 1'b0 ||
                      count_out !== 9'd0 || dash_dit !== 1'b0 || space !== 1'b0) begin
            failures++; $display("FAIL ar_outputs got v=%0b c=%0d l=%0d o=%0b cnt=%0d dd=%0b sp=%0b exp all 0",
                                 evt_valid, evt_code, evt_len, overrun, count_out, dash_dit, space);
        end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL ar_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
        @(negedge clk);
        reset = 1'b0;
        evt_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (evt_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0 || dut.state_q !== ST_IDLE) begin
            failures++; $display("FAIL ar_no_event got events=%0d st=%0d exp 0/IDLE", seen, dut.state_q);
        end
    endtask

    initial begin
        test_reset();
        test_dit();
        test_dash_letter_intra();
        test_word_timeout();
        test_overrun();
        test_back_to_back();
        test_ref_zero();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_interval_classifier.md
Name: morse_interval_classifier

Overview:
- Parametrised successor to the single-button texter saturation counter: times both key-down (mark) and key-up (gap) runs with a shared prescaled saturating counter.
- Classifies each run against a speed reference and emits one event per run through a valid/ready handshake.
- Sits between the debounced key input and the speed tracker / Morse decoder.
- Keeps the legacy live outputs (count_out, dash_dit, space) for existing consumers.

Parameters:
- PRESCALE, 60000, clock cycles per timing tick (must be ≥ 2).
- CNT_W, 12, internal tick counter width; saturates at 2^CNT_W-1.
- OUT_W, 9, width of ref_in, count_out and evt_len; CNT_W ≥ OUT_W+2 is required.

Ports:
- clk  in  1  system clock (27 MHz).
- reset  in  1  asynchronous, active-high reset.
- key  in  1  debounced key level, synchronous to clk (1 = mark).
- ref_in  in  OUT_W  dit/dash threshold in ticks (≈2 units), from the speed tracker.
- evt_valid  out  1  event holding register full.
- evt_ready  in  1  consumer accepts the event when evt_valid=1.
- evt_code  out  3  0=DIT, 1=DASH, 2=INTRA gap, 3=LETTER gap, 4=WORD gap.
- evt_len  out  OUT_W  run length in ticks, saturated to all-ones.
- overrun  out  1  sticky flag: an event was dropped because the holding register was full.
- count_out  out  OUT_W  live run count, saturated to all-ones.
- dash_dit  out  1  live: count > ref_in.
- space  out  1  live: count > 3*ref_in.

Behaviour:
- Reset (async): state IDLE, count=0, prescaler=0, key_q=0. Outputs: evt_valid=0, evt_code=0, evt_len=0, overrun=0, count_out=0, dash_dit=0, space=0.
- key is registered into key_q. An edge is key != key_q in the current cycle.
- Prescaler counts 0..PRESCALE-1. A tick fires when the prescaler is at PRESCALE-1; the prescaler then wraps to 0. On a tick, count increments unless it is at 2^CNT_W-1 (saturation; no wrap).
- On any edge, prescaler and count clear to 0 in the same cycle, so a run of N cycles ends with count = floor(N/PRESCALE).
- sp_ref = 3*ref_in, computed at CNT_W width and re-evaluated continuously (no latch).
- State machine:
  - IDLE: count held at 0. Rising edge -> MARK. A gap is never reported from IDLE.
  - MARK: falling edge emits DIT if count ≤ ref_in, else DASH -> GAP.
  - GAP, rising edge:
    - count ≤ ref_in emits INTRA -> MARK.
    - ref_in < count ≤ sp_ref emits LETTER -> MARK.
  - GAP, no edge: when count > sp_ref, emit WORD once (timeout flush) -> GAP_DONE.
  - GAP_DONE: count keeps running/saturating. Rising edge -> MARK with no event.
- Event emission:
  - evt_len = min(count, 2^OUT_W-1) taken before the clear.
  - The event is loaded into the holding register on the clock after the emitting condition; evt_valid rises 1 cycle after the edge or timeout.
- Handshake:
  - evt_valid && evt_ready clears evt_valid next cycle.
  - A new emission in the same cycle as acceptance loads the new event (evt_valid stays 1).
  - A new emission while evt_valid=1 and evt_ready=0 drops the new event, keeps the old one, and sets overrun. overrun is cleared only by reset.
  - evt_code and evt_len hold stable while evt_valid=1.
- Live outputs (registered, update each cycle from the current count):
  - count_out = all-ones if count ≥ 2^OUT_W-1, else count[OUT_W-1:0].
  - dash_dit and space as defined in Ports. In IDLE all three are 0.
- ref_in = 0: any run with count ≥ 1 classifies as DASH or WORD; no special casing.
- Reset asserted mid-run: run discarded, no event, pending event lost.

Decomposition:
- Shared package morse_pkg: event code constants (EVT_DIT..EVT_WORD), state encoding (IDLE, MARK, GAP, GAP_DONE), EVT_CODE_W=3.
- One natural sub-module: tick_prescaler (PRESCALE parameter; tick out; sync clear in; async reset). Reusable by the speed tracker.
- The classifier FSM, saturating counter and holding register stay in the top module.

Test Plan (PRESCALE=4, CNT_W=12, OUT_W=9, evt_ready=1 unless stated):
- ref_in=2. Key high 8 cycles, then low -> one event DIT, evt_len=2, evt_valid 1 cycle after the falling edge, for 1 cycle.
- ref_in=2. Key high 12 cycles -> DASH, len=3. Then low 12 cycles, then high -> LETTER, len=3. Low 8 cycles, then high -> INTRA, len=2.
- ref_in=2. Mark, then key held low -> WORD with len=7 emitted once at the 7th tick (cycle 28 of the gap). Following rising edge -> no gap event; next mark classified normally.
- ref_in=2, evt_ready=0. DIT then INTRA -> first event held, second dropped, overrun=1. Raise evt_ready -> evt_valid drops next cycle, overrun stays 1.
- ref_in=511. Key high 2^12*4+40 cycles -> count saturates at 4095, count_out=511, dash_dit=1, space=1. Falling edge -> DASH with len=511.
- Assert reset asynchronously mid-mark with evt_valid=1 -> all outputs 0 immediately, state IDLE. Next key-low period after reset produces no event.
